// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with wrap or saturate, sync clear/load,
// combinational terminal count for cascading, and overflow/load-error reporting.
module param_updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter bit SATURATE = 1'b0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             ovf,
    output logic             ovf_flag,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Y = WIDTH'(RST_VAL);
    localparam bit               FULL  = (MODULUS == (1 << WIDTH));

    logic             at_top;
    logic             at_zero;
    logic             legal_y;
    logic             load_ok;
    logic [WIDTH-1:0] y_next;
    logic             ovf_next;
    logic             flag_next;
    logic             err_next;

    assign at_top  = (y == TOP);
    assign at_zero = (y == '0);

    // With a full power-of-two modulus every encoding is legal, so the range
    // compares are dropped rather than left as constant-true logic.
    generate
        if (FULL) begin : g_full
            assign legal_y = 1'b1;
            assign load_ok = 1'b1;
        end else begin : g_partial
            assign legal_y = (y <= TOP);
            assign load_ok = (load_val <= TOP);
        end
    endgenerate

    assign tc = w & (up ? at_top : at_zero);

    always_comb begin
        y_next    = y;
        ovf_next  = 1'b0;
        flag_next = ovf_flag;
        err_next  = 1'b0;
        if (clr) begin
            y_next    = '0;
            flag_next = 1'b0;
        end else if (load) begin
            if (load_ok) begin
                y_next = load_val;
            end else begin
                err_next = 1'b1;
            end
        end else if (w) begin
            if (!legal_y) begin
                // Out-of-range state: snap back to the bound in the count direction.
                y_next   = up ? '0 : TOP;
                ovf_next = 1'b1;
            end else if (up) begin
                if (at_top) begin
                    y_next    = SATURATE ? y : '0;
                    ovf_next  = 1'b1;
                    flag_next = 1'b1;
                end else begin
                    y_next = WIDTH'(y + 1'b1);
                end
            end else begin
                if (at_zero) begin
                    y_next    = SATURATE ? y : TOP;
                    ovf_next  = 1'b1;
                    flag_next = 1'b1;
                end else begin
                    y_next = WIDTH'(y - 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y        <= RST_Y;
            ovf      <= 1'b0;
            ovf_flag <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            y        <= y_next;
            ovf      <= ovf_next;
            ovf_flag <= flag_next;
            ld_err   <= err_next;
        end
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's 3-bit JK-style enable counter (w-gated, y = state).
- Adds generic width and modulus, up/down direction, synchronous clear, parallel load, and a wrap or saturate mode.
- Adds a combinational terminal-count output for cascading, an overflow pulse and a sticky overflow flag.
- Used as the generic counting FSM in the TRF datapaths and as a cascadable prescaler.

Parameters:
- WIDTH, 3: counter/state width in bits.
- MODULUS, 8: count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; the bench asserts this at elaboration.
- SATURATE, 0: 0 = wrap at the bound, 1 = hold at the bound.
- RST_VAL, 0: value of y on reset. Must be < MODULUS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- w  in  1  count enable; one step per clk edge while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0; also clears ovf_flag.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- y  out  WIDTH  current count (registered).
- tc  out  1  terminal count, combinational.
- ovf  out  1  one-cycle overflow/underflow pulse (registered).
- ovf_flag  out  1  sticky overflow flag.
- ld_err  out  1  one-cycle pulse: a load was rejected (registered).

Behaviour:
- Reset: rst=1 forces immediately, independent of clk: y=RST_VAL, ovf=0, ovf_flag=0, ld_err=0. All state holds while rst is high; the first update happens on the first clk rising edge after rst falls.
- Priority per edge, highest first: clr > load > w. Lower-priority inputs are ignored when a higher one is active.
- clr=1: y<=0, ovf_flag<=0, ovf<=0, ld_err<=0.
- load=1 with load_val < MODULUS: y<=load_val, ovf<=0, ld_err<=0.
- load=1 with load_val >= MODULUS: y holds, ld_err<=1 for exactly one cycle, ovf<=0.
- w=1, up=1:
  - y < MODULUS-1: y<=y+1.
  - y == MODULUS-1, SATURATE=0: y<=0, ovf<=1, ovf_flag<=1.
  - y == MODULUS-1, SATURATE=1: y holds, ovf<=1, ovf_flag<=1.
- w=1, up=0:
  - y > 0: y<=y-1.
  - y == 0, SATURATE=0: y<=MODULUS-1, ovf<=1, ovf_flag<=1.
  - y == 0, SATURATE=1: y holds, ovf<=1, ovf_flag<=1.
- w=0 with no clr/load: y holds; ovf<=0, ld_err<=0.
- ovf and ld_err are pulses: high only in the cycle after the triggering edge. They deassert on the next edge unless retriggered, so consecutive bound hits give a continuous high.
- ovf_flag stays set until clr or rst.
- tc = w & (up ? y==MODULUS-1 : y==0). It is combinational and asserted in the same cycle as the edge that will wrap/saturate. Cascading is done by wiring tc of stage N to w of stage N+1.
- Arithmetic: comparisons and increments are unsigned WIDTH-bit. With MODULUS=2**WIDTH, wrap is the natural rollover with no illegal states.
- Illegal state recovery: if y >= MODULUS, any counting edge forces y<=0 (up) or y<=MODULUS-1 (down) with ovf<=1. This state is unreachable in normal use.
- Direction change mid-count takes effect on the same edge, with no extra latency.
- rst asserted mid-count aborts immediately: y=RST_VAL and the flags clear within the same cycle, with no clock needed.

Test Plan:
- Reset and basic count, defaults (WIDTH=3, MODULUS=8, SATURATE=0):
  - Pulse rst mid-cycle -> y=0 asynchronously.
  - Then w=1, up=1 for 9 edges -> y = 1..7, 0, 1.
  - tc high while y=7; ovf high one cycle after the 7->0 edge; ovf_flag=1.
- Modulo down-count (MODULUS=6, SATURATE=0):
  - Load 2, then w=1, up=0 for 4 edges -> y = 1, 0, 5, 4.
  - ovf pulse after the 0->5 edge.
- Saturate (MODULUS=6, SATURATE=1):
  - Load 4, then up=1, w=1 for 4 edges -> y = 5, 5, 5, 5.
  - ovf high for the 3 cycles after edges 2-4.
  - Then up=0 for 2 edges -> y = 4, 3.
- Load and priority (MODULUS=6):
  - load_val=7 -> y holds, ld_err pulses once.
  - clr=1 together with load=1 and load_val=3 -> y=0, ovf_flag=0.
  - load=1 with w=1 and load_val=3 -> y=3 (load wins).
- Cascade: two instances, WIDTH=3, MODULUS=8, tc0 driving w1, w0=1 for 64 edges.
  - y1 increments only on edges where y0=7.
  - After 64 edges, {y1,y0}=0 and stage 1 pulses ovf once.
- Async reset mid-operation:
  - Counting at y=5, assert rst between clock edges -> y=RST_VAL, ovf_flag=0 without a clk edge.
  - Deassert rst -> counting resumes from RST_VAL on the next edge.
